alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request a macro operation
- op  in  2  00 LOGIC, 01 ADD, 10 SUB, 11 illegal
- chain  in  1  1 = use previous R as X1 (operand a ignored)
- flag_req  in  1  1 = also read FLAG register after result
- clr  in  1  request ALU CLEAR
- a  in  4  operand for X1
- b  in  4  operand for X2
- bus_in  in  4  shared bus value returned by ALU
- ready  out  1  high only in IDLE
- instr  out  4  ALU instruction to the ALU decoder
- bus_out  out  4  operand driven onto the bus
- bus_oe  out  1  bus_out valid/drive enable
- result  out  4  last captured R value
- flags  out  4  last captured FLAG value
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-request pulse

Function
REQ-003 The FSM SHALL use states IDLE, LD_X1, LD_X2, EXEC, RD_R, RD_F, DONE and CLR; instr, bus_out and bus_oe SHALL decode from the current state only (Moore).
REQ-004 Per-state outputs SHALL be:
- IDLE: instr=0 (NOP)
- LD_X1: instr=1, bus_oe=1, bus_out=latched a; if chain, instr=9 and bus_oe=0
- LD_X2: instr=2, bus_oe=1, bus_out=latched b
- EXEC: instr=4/5/6 for op 00/01/10
- RD_R: instr=7
- RD_F: instr=8
- DONE: instr=0, done=1
- CLR: instr=F
REQ-005 In all other cases bus_oe SHALL be 0 and bus_out SHALL be 0.
REQ-006 In IDLE, clr=1 SHALL move to CLR, with priority over start.
REQ-007 In IDLE, start=1 with op!=11 SHALL latch op, chain, flag_req, a and b, then move to LD_X1.
REQ-008 In IDLE, start=1 with op=11 SHALL pulse err for one cycle and stay in IDLE, with no other effect.
REQ-009 Transitions SHALL be LD_X1->LD_X2->EXEC->RD_R; RD_R->RD_F if the latched flag_req=1, else RD_R->DONE; RD_F->DONE; DONE->IDLE; CLR->IDLE.
REQ-010 At the end of the RD_R cycle, result SHALL load bus_in.
REQ-011 At the end of the RD_F cycle, flags SHALL load bus_in.
REQ-012 result and flags SHALL otherwise hold their values.
REQ-013 Latency SHALL be as follows, counting the acceptance edge as cycle 0: done high in cycle 5 (no flag_req) or cycle 6 (flag_req); ready high again in cycle 6 or 7.
REQ-014 start asserted while not in IDLE SHALL be ignored; it SHALL not be queued.
REQ-015 Input changes after acceptance SHALL NOT affect the running sequence.
REQ-016 clr=1 in any busy state other than DONE SHALL abort: next state CLR, and done SHALL NOT be pulsed for the aborted operation.
REQ-017 clr=1 in DONE SHALL go to CLR after done pulses.
REQ-018 In CLR, result and flags SHALL be cleared to 0 at the end of the cycle.
REQ-019 chain=1 with no prior result SHALL still issue instr 9; the ALU then uses its current R value (0 after reset or clear).
REQ-020 Back-to-back operation SHALL be supported: start held high SHALL be accepted in the first IDLE cycle after DONE.

Reset
REQ-021 When rst=1 at a clock edge, the block SHALL enter IDLE and set instr=0, bus_out=0, bus_oe=0, result=0, flags=0, done=0 and err=0; ready SHALL be 1 in the following cycle.
REQ-022 Reset SHALL override start and clr and abort any sequence in progress immediately, with no done pulse.
REQ-023 All latched request fields SHALL reset to 0.

Verification
REQ-024 ADD without flags: op=01, a=3, b=5, bus_in=8 during RD_R -> instr sequence 1,2,5,7,0; bus_out 3 then 5; result=8; done in cycle 5 only.
REQ-025 SUB with flags: op=10, flag_req=1, bus_in=2 in RD_R and 4'b0101 in RD_F -> instr 1,2,6,7,8; result=2; flags=5; done in cycle 6.
REQ-026 Chain: op=00, chain=1, b=F -> instr 9,2,4,7; bus_oe=0 in LD_X1; bus_out=F in LD_X2.
REQ-027 Illegal request and priority: op=11 with start -> err one cycle, ready stays 1; start and clr together in IDLE -> instr F for one cycle, result=0, start dropped.
REQ-028 Abort: clr in EXEC -> next instr=F, no done, result=0; rst in LD_X2 -> next cycle instr=0, ready=1, all outputs 0.
REQ-029 Ignored start: start asserted during RD_R -> not queued; back-to-back start held high -> second LD_X1 immediately after IDLE.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequences one ALU macro operation (load X1, load X2, execute,
// read R, optionally read FLAG) over a shared 4-bit bus. Includes abort and
// clear handling.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       chain,
    input  logic       flag_req,
    input  logic       clr,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] bus_in,
    output logic       ready,
    output logic [3:0] instr,
    output logic [3:0] bus_out,
    output logic       bus_oe,
    output logic [3:0] result,
    output logic [3:0] flags,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, LD_X1, LD_X2, EXEC, RD_R, RD_F, DONE, CLR
    } state_t;

    state_t     state;
    logic [1:0] op_q;
    logic       chain_q;
    logic       flag_req_q;
    logic [3:0] a_q;
    logic [3:0] b_q;

    // Sequencer: request capture, step order, abort on clr, R/FLAG capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 2'b00;
            chain_q    <= 1'b0;
            flag_req_q <= 1'b0;
            a_q        <= 4'h0;
            b_q        <= 4'h0;
            result     <= 4'h0;
            flags      <= 4'h0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLR;
                    end else if (start) begin
                        if (op == 2'b11) begin
                            err <= 1'b1;
                        end else begin
                            op_q       <= op;
                            chain_q    <= chain;
                            flag_req_q <= flag_req;
                            a_q        <= a;
                            b_q        <= b;
                            state      <= LD_X1;
                        end
                    end
                end
                LD_X1: state <= clr ? CLR : LD_X2;
                LD_X2: state <= clr ? CLR : EXEC;
                EXEC:  state <= clr ? CLR : RD_R;
                RD_R: begin
                    result <= bus_in;
                    if (clr)             state <= CLR;
                    else if (flag_req_q) state <= RD_F;
                    else                 state <= DONE;
                end
                RD_F: begin
                    flags <= bus_in;
                    state <= clr ? CLR : DONE;
                end
                // done is already visible this cycle, so a clr here only
                // redirects the return path.
                DONE:  state <= clr ? CLR : IDLE;
                CLR: begin
                    result <= 4'h0;
                    flags  <= 4'h0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode of ALU instruction and bus drive from the current state.
    always_comb begin
        instr   = 4'h0;
        bus_out = 4'h0;
        bus_oe  = 1'b0;
        case (state)
            LD_X1: begin
                if (chain_q) begin
                    instr = 4'h9;
                end else begin
                    instr   = 4'h1;
                    bus_oe  = 1'b1;
                    bus_out = a_q;
                end
            end
            LD_X2: begin
                instr   = 4'h2;
                bus_oe  = 1'b1;
                bus_out = b_q;
            end
            EXEC: begin
                case (op_q)
                    2'b01:   instr = 4'h5;
                    2'b10:   instr = 4'h6;
                    default: instr = 4'h4;
                endcase
            end
            RD_R:    instr = 4'h7;
            RD_F:    instr = 4'h8;
            CLR:     instr = 4'hF;
            default: instr = 4'h0;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq. Expected sequences are pushed when
// a request is driven and popped when done is observed.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst, start, chain, flag_req, clr;
    logic [1:0] op;
    logic [3:0] a, b, bus_in;
    logic       ready, bus_oe, done, err;
    logic [3:0] instr, bus_out, result, flags;

    // ALU model response on the shared bus
    logic [3:0] rval, fval;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] seq;
        logic [4:0]  x1;
        logic [3:0]  x2;
        int          lat;
        logic [3:0]  res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sbq[$];
    logic [3:0] m_result = 4'h0;
    logic [3:0] m_flags  = 4'h0;

    // monitor state
    logic [23:0] mon_seq;
    logic [4:0]  mon_x1;
    logic [3:0]  mon_x2;
    int          mon_cyc;
    int          done_cnt = 0;

    alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .chain(chain),
        .flag_req(flag_req), .clr(clr), .a(a), .b(b), .bus_in(bus_in),
        .ready(ready), .instr(instr), .bus_out(bus_out), .bus_oe(bus_oe),
        .result(result), .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign bus_in = (instr == 4'h7) ? rval : (instr == 4'h8) ? fval : 4'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: accumulate the busy-state trace and compare on done.
    always @(negedge clk) begin
        if (rst || ready) begin
            mon_seq = 24'h0;
            mon_cyc = 0;
        end else if (!done) begin
            if (mon_cyc == 0) mon_x1 = {bus_oe, bus_out};
            if (mon_cyc == 1) mon_x2 = bus_out;
            mon_seq = {mon_seq[19:0], instr};
            mon_cyc++;
        end else begin
            exp_t e;
            done_cnt++;
            if (sbq.size() == 0) begin
                check("sb_unexpected_done", 32'(sbq.size()), 1);
            end else begin
                e = sbq.pop_front();
                check("sb_seq", 32'(mon_seq), 32'(e.seq));
                check("sb_x1", 32'(mon_x1), 32'(e.x1));
                check("sb_x2", 32'(mon_x2), 32'(e.x2));
                check("sb_latency", 32'(mon_cyc + 1), 32'(e.lat));
                check("sb_result", 32'(result), 32'(e.res));
                check("sb_flags", 32'(flags), 32'(e.flg));
            end
        end
    end

    function automatic exp_t make_exp(input logic [1:0] o, input logic ch, input logic fr,
                                      input logic [3:0] xa, input logic [3:0] xb,
                                      input logic [3:0] rv, input logic [3:0] fv);
        exp_t e;
        e.seq = ch ? 24'h9 : 24'h1;
        e.seq = {e.seq[19:0], 4'h2};
        e.seq = {e.seq[19:0], 4'h4 + {2'b00, o}};
        e.seq = {e.seq[19:0], 4'h7};
        if (fr) e.seq = {e.seq[19:0], 4'h8};
        e.x1  = ch ? 5'h00 : {1'b1, xa};
        e.x2  = xb;
        e.lat = fr ? 6 : 5;
        e.res = rv;
        e.flg = fr ? fv : m_flags;
        return e;
    endfunction

    // Drive one accepted request from IDLE; returns at the LD_X1 negedge
    // with the request inputs scrambled.
    task automatic issue(input logic [1:0] o, input logic ch, input logic fr,
                         input logic [3:0] xa, input logic [3:0] xb,
                         input logic [3:0] rv, input logic [3:0] fv);
        exp_t e;
        @(negedge clk);
        op = o; chain = ch; flag_req = fr; a = xa; b = xb;
        rval = rv; fval = fv; start = 1'b1;
        e = make_exp(o, ch, fr, xa, xb, rv, fv);
        sbq.push_back(e);
        m_result = rv;
        if (fr) m_flags = fv;
        @(negedge clk);
        start = 1'b0;
        op = ~o; chain = ~ch; flag_req = ~fr; a = ~xa; b = ~xb;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", 32'(ready), 1);
    endtask

    task automatic wait_instr(input logic [3:0] v);
        int n = 0;
        while (instr !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_instr", 32'(instr), 32'(v));
    endtask

    initial begin
        int dn0;
        exp_t dummy;
        rst = 1'b1; start = 1'b0; op = 2'b00; chain = 1'b0; flag_req = 1'b0;
        clr = 1'b0; a = 4'h0; b = 4'h0; rval = 4'h0; fval = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 1);
        check("rst_instr", 32'(instr), 0);
        check("rst_bus", 32'({bus_oe, bus_out}), 0);
        check("rst_result", 32'(result), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_done_err", 32'({done, err}), 0);
        rst = 1'b0;

        // ADD without flags
        issue(2'b01, 1'b0, 1'b0, 4'h3, 4'h5, 4'h8, 4'h0);
        wait_ready();
        check("add_result", 32'(result), 8);

        // SUB with flags
        issue(2'b10, 1'b0, 1'b1, 4'h9, 4'h7, 4'h2, 4'h5);
        wait_ready();
        check("sub_flags", 32'(flags), 5);

        // LOGIC chained on previous R
        issue(2'b00, 1'b1, 1'b0, 4'h6, 4'hF, 4'h7, 4'h0);
        wait_ready();

        // illegal op: err pulse only
        @(negedge clk);
        op = 2'b11; start = 1'b1; a = 4'h1; b = 4'h2;
        @(negedge clk);
        start = 1'b0;
        check("ill_err", 32'(err), 1);
        check("ill_ready", 32'(ready), 1);
        @(negedge clk);
        check("ill_err_low", 32'(err), 0);
        check("ill_ready2", 32'(ready), 1);
        check("ill_result", 32'(result), 7);

        // start and clr together: clear wins, start dropped
        @(negedge clk);
        op = 2'b01; start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        check("clr_instr", 32'(instr), 15);
        @(negedge clk);
        check("clr_ready", 32'(ready), 1);
        check("clr_result", 32'({result, flags}), 0);
        m_result = 4'h0; m_flags = 4'h0;
        @(negedge clk);
        check("clr_no_start", 32'({ready, instr}), 32'h10);

        // abort in EXEC
        issue(2'b01, 1'b0, 1'b0, 4'h3, 4'h4, 4'h9, 4'h0);
        wait_ready();
        issue(2'b10, 1'b0, 1'b1, 4'h8, 4'h1, 4'hC, 4'hA);
        dn0 = done_cnt;
        wait_instr(4'h6);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_instr", 32'(instr), 15);
        @(negedge clk);
        check("abort_ready", 32'(ready), 1);
        check("abort_clear", 32'({result, flags}), 0);
        check("abort_no_done", 32'(done_cnt), 32'(dn0));
        dummy = sbq.pop_front();
        m_result = 4'h0; m_flags = 4'h0;

        // reset in LD_X2
        issue(2'b01, 1'b0, 1'b1, 4'h2, 4'h2, 4'h6, 4'h3);
        wait_ready();
        issue(2'b00, 1'b0, 1'b0, 4'hA, 4'hB, 4'h1, 4'h0);
        dn0 = done_cnt;
        @(negedge clk);
        check("rst2_in_ldx2", 32'(instr), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_idle", 32'({ready, instr, bus_oe, bus_out}), 32'h200);
        check("rst2_regs", 32'({result, flags, done, err}), 0);
        check("rst2_no_done", 32'(done_cnt), 32'(dn0));
        dummy = sbq.pop_front();
        m_result = 4'h0; m_flags = 4'h0;

        // start during RD_R is not queued
        issue(2'b01, 1'b0, 1'b0, 4'h4, 4'h4, 4'h5, 4'h0);
        wait_instr(4'h7);
        op = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready();
        repeat (3) begin
            @(negedge clk);
            check("no_queue_ready", 32'(ready), 1);
        end
        check("no_queue_sb", 32'(sbq.size()), 0);

        // back-to-back with start held high
        begin
            exp_t e;
            int n = 0;
            @(negedge clk);
            op = 2'b01; chain = 1'b0; flag_req = 1'b0; a = 4'h1; b = 4'h2;
            rval = 4'h3; start = 1'b1;
            e = make_exp(2'b01, 1'b0, 1'b0, 4'h1, 4'h2, 4'h3, 4'h0);
            sbq.push_back(e);
            m_result = 4'h3;
            @(negedge clk);
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done1", 32'(done), 1);
            op = 2'b10; flag_req = 1'b1; a = 4'hE; b = 4'hD; fval = 4'hB;
            e = make_exp(2'b10, 1'b0, 1'b1, 4'hE, 4'hD, 4'h3, 4'hB);
            sbq.push_back(e);
            m_flags = 4'hB;
            @(negedge clk);
            check("b2b_idle", 32'(ready), 1);
            @(negedge clk);
            check("b2b_ldx1", 32'(instr), 1);
            start = 1'b0;
            wait_ready();
            check("b2b_sb", 32'(sbq.size()), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
